// File: rtl/intdiv_sched.sv
// Two-requester front end for a fixed-latency pipelined divider: round-robin
// arbitration, credit-limited issue, divide-by-zero/overflow fix-up, and an in-order result FIFO.
module intdiv_sched #(
  parameter int N     = 4,
  parameter int LAT   = 4,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic [N-1:0] req0_x,
  input  logic [N-1:0] req0_y,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [N-1:0] req1_x,
  input  logic [N-1:0] req1_y,
  output logic         req1_ready,
  output logic [N-1:0] div_x,
  output logic [N-1:0] div_y,
  input  logic [N-1:0] div_z,
  input  logic [N-1:0] div_r,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_z,
  output logic [N-1:0] res_r,
  output logic         res_id,
  output logic         res_dz,
  output logic         res_ovf,
  output logic         busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1) + 1;
  localparam logic [N-1:0] MIN_V = {1'b1, {(N-1){1'b0}}};

  typedef struct packed {
    logic         id;
    logic         dz;
    logic         ovf;
    logic [N-1:0] x;
  } tag_t;

  typedef struct packed {
    logic [N-1:0] z;
    logic [N-1:0] r;
    logic         id;
    logic         dz;
    logic         ovf;
  } ent_t;

  function automatic logic is_ovf(input logic [N-1:0] x, input logic [N-1:0] y);
    return (x == MIN_V) && (y == {N{1'b1}});
  endfunction

  // Replace the divider's output for the two cases it cannot represent.
  function automatic ent_t fix_result(input tag_t t, input logic [N-1:0] z,
                                      input logic [N-1:0] r);
    ent_t e;
    e.id  = t.id;
    e.dz  = t.dz;
    e.ovf = t.ovf;
    e.z   = z;
    e.r   = r;
    if (t.dz) begin
      e.z = {N{1'b1}};
      e.r = t.x;
    end else if (t.ovf) begin
      e.z = MIN_V;
      e.r = '0;
    end
    return e;
  endfunction

  function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic                 ptr_q, ptr_d;
  logic [LAT:0]         tvld_q;
  tag_t [LAT:0]         tag_q;
  logic [CW-1:0]        inflight_q, inflight_d;
  logic [CW-1:0]        count_q, count_d;
  logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
  ent_t                 mem_q [DEPTH];
  logic signed [N-1:0]  dx_q, dx_d, dy_q, dy_d;

  logic                 credit, gnt1, acc, wr_en, pop;
  logic signed [N-1:0]  acc_x, acc_y;
  tag_t                 acc_tag;
  ent_t                 wr_ent, head;

  always_comb begin
    credit     = ({1'b0, inflight_q} + {1'b0, count_q}) < (CW+1)'(DEPTH);
    gnt1       = req1_valid && (!req0_valid || ptr_q);
    req0_ready = !reset && credit && req0_valid && !gnt1;
    req1_ready = !reset && credit && gnt1;
    acc        = req0_ready || req1_ready;
    acc_x      = gnt1 ? req1_x : req0_x;
    acc_y      = gnt1 ? req1_y : req0_y;
    acc_tag.id  = gnt1;
    acc_tag.dz  = (acc_y == '0);
    acc_tag.ovf = is_ovf(acc_x, acc_y);
    acc_tag.x   = acc_x;
    ptr_d      = acc ? ~gnt1 : ptr_q;
    dx_d       = acc ? acc_x : dx_q;
    dy_d       = acc ? acc_y : dy_q;
  end

  // Divider output stage: the tag at the end of the shift register lines up with div_z/div_r.
  always_comb begin
    wr_en      = tvld_q[LAT];
    wr_ent     = fix_result(tag_q[LAT], div_z, div_r);
    pop        = res_valid && res_ready;
    count_d    = count_q + CW'(wr_en) - CW'(pop);
    inflight_d = inflight_q + CW'(acc) - CW'(wr_en);
    wr_d       = wr_en ? nxt_ptr(wr_q) : wr_q;
    rd_d       = pop ? nxt_ptr(rd_q) : rd_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q      <= 1'b0;
      tvld_q     <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
    end else begin
      ptr_q      <= ptr_d;
      tvld_q     <= {tvld_q[LAT-1:0], acc};
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
    end
  end

  always_ff @(posedge clock) begin
    tag_q <= {tag_q[LAT-1:0], acc_tag};
    if (wr_en) mem_q[wr_q] <= wr_ent;
  end

  // FIFO head presentation; zeroed whenever nothing is buffered.
  always_comb begin
    head      = mem_q[rd_q];
    res_valid = (count_q != '0);
    res_z     = res_valid ? head.z   : '0;
    res_r     = res_valid ? head.r   : '0;
    res_id    = res_valid ? head.id  : 1'b0;
    res_dz    = res_valid ? head.dz  : 1'b0;
    res_ovf   = res_valid ? head.ovf : 1'b0;
    busy      = (inflight_q != '0) || (count_q != '0);
    div_x     = dx_q;
    div_y     = dy_q;
  end

endmodule

// File: tb/tb_intdiv_sched.sv
// Directed bench for intdiv_sched with a behavioural LAT-cycle divider model.
module tb_intdiv_sched;

  localparam int N = 4, LAT = 4, DEPTH = 4;

  logic clock = 1'b0, reset = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b0;
  logic [N-1:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
  logic req0_ready, req1_ready, res_valid, res_id, res_dz, res_ovf, busy;
  logic [N-1:0] div_x, div_y, div_z, div_r, res_z, res_r;

  intdiv_sched #(.N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y), .req1_ready(req1_ready),
    .div_x(div_x), .div_y(div_y), .div_z(div_z), .div_r(div_r),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_z(res_z), .res_r(res_r), .res_id(res_id), .res_dz(res_dz), .res_ovf(res_ovf),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Divider model: result for operands loaded at edge t is visible after edge t+LAT.
  logic signed [N-1:0] px [LAT] = '{default: '0};
  logic signed [N-1:0] py [LAT] = '{default: '0};
  always @(posedge clock) begin
    px[0] <= $signed(div_x);
    py[0] <= $signed(div_y);
    for (int k = 1; k < LAT; k++) begin
      px[k] <= px[k-1];
      py[k] <= py[k-1];
    end
  end

  function automatic logic signed [N-1:0] mq(input logic signed [N-1:0] x, input logic signed [N-1:0] y);
    if (y == 0) return '0;
    return x / y;
  endfunction
  function automatic logic signed [N-1:0] mr(input logic signed [N-1:0] x, input logic signed [N-1:0] y);
    if (y == 0) return '0;
    return x % y;
  endfunction
  assign div_z = mq(px[LAT-1], py[LAT-1]);
  assign div_r = mr(px[LAT-1], py[LAT-1]);

  typedef struct {
    logic id;
    logic signed [N-1:0] x, y, z, r;
    logic dz, ovf;
  } vec_t;

  typedef struct {
    int z, r, id;
  } res_t;

  int n_chk = 0, n_err = 0;
  vec_t vt [12];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset;
    @(negedge clock);
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int k;
    bit seen;
    @(negedge clock);
    res_ready = 1'b1;
    if (v.id == 1'b0) begin req0_valid = 1'b1; req0_x = v.x; req0_y = v.y; end
    else begin req1_valid = 1'b1; req1_x = v.x; req1_y = v.y; end
    #1;
    chk($sformatf("v%0d_ready", idx), int'(v.id ? req1_ready : req0_ready), 1);
    @(posedge clock);
    @(negedge clock);
    req0_valid = 1'b0; req1_valid = 1'b0;
    k = 0; seen = 1'b0;
    while (!seen && k < 20) begin
      #1;
      if (res_valid) seen = 1'b1;
      else begin @(negedge clock); k++; end
    end
    chk($sformatf("v%0d_seen", idx), int'(seen), 1);
    chk($sformatf("v%0d_latency", idx), k, LAT + 1);
    chk($sformatf("v%0d_z", idx), int'($signed(res_z)), int'(v.z));
    chk($sformatf("v%0d_r", idx), int'($signed(res_r)), int'(v.r));
    chk($sformatf("v%0d_id", idx), int'(res_id), int'(v.id));
    chk($sformatf("v%0d_dz", idx), int'(res_dz), int'(v.dz));
    chk($sformatf("v%0d_ovf", idx), int'(res_ovf), int'(v.ovf));
    @(posedge clock);
    @(negedge clock);
    #1;
    chk($sformatf("v%0d_busy_after", idx), int'(busy), 0);
  endtask

  task automatic chk_alt(input string nm, input res_t q [$], input int n_exp);
    chk({nm, "_count"}, q.size(), n_exp);
    for (int i = 0; i < q.size() && i < n_exp; i++) begin
      chk($sformatf("%s_%0d_id", nm, i), q[i].id, i % 2);
      chk($sformatf("%s_%0d_z", nm, i), q[i].z, (i % 2) ? -1 : 2);
      chk($sformatf("%s_%0d_r", nm, i), q[i].r, (i % 2) ? -2 : 1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int accs[$];
    res_t rq[$];
    int nacc, nres, hz, hr, hid;
    bit held, both;

    vt[0]  = '{1'b0,  4'sd7,  4'sd3,  4'sd2,  4'sd1, 1'b0, 1'b0};
    vt[1]  = '{1'b1, -4'sd6,  4'sd4, -4'sd1, -4'sd2, 1'b0, 1'b0};
    vt[2]  = '{1'b0,  4'sd5,  4'sd0, -4'sd1,  4'sd5, 1'b1, 1'b0};
    vt[3]  = '{1'b0, -4'sd8, -4'sd1, -4'sd8,  4'sd0, 1'b0, 1'b1};
    vt[4]  = '{1'b1, -4'sd7,  4'sd2, -4'sd3, -4'sd1, 1'b0, 1'b0};
    vt[5]  = '{1'b0,  4'sd7, -4'sd2, -4'sd3,  4'sd1, 1'b0, 1'b0};
    vt[6]  = '{1'b1, -4'sd8,  4'sd1, -4'sd8,  4'sd0, 1'b0, 1'b0};
    vt[7]  = '{1'b0,  4'sd0,  4'sd5,  4'sd0,  4'sd0, 1'b0, 1'b0};
    vt[8]  = '{1'b1, -4'sd8,  4'sd0, -4'sd1, -4'sd8, 1'b1, 1'b0};
    vt[9]  = '{1'b0, -4'sd1, -4'sd1,  4'sd1,  4'sd0, 1'b0, 1'b0};
    vt[10] = '{1'b1,  4'sd6, -4'sd3, -4'sd2,  4'sd0, 1'b0, 1'b0};
    vt[11] = '{1'b0, -4'sd7,  4'sd7, -4'sd1,  4'sd0, 1'b0, 1'b0};

    // Reset state and readies held low during reset.
    @(negedge clock);
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    req0_x = 4'd7; req0_y = 4'd3; req1_x = 4'd2; req1_y = 4'd1;
    @(negedge clock);
    #1;
    chk("rst_ready0", int'(req0_ready), 0);
    chk("rst_ready1", int'(req1_ready), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_res_z", int'(res_z), 0);
    chk("rst_res_r", int'(res_r), 0);
    chk("rst_res_flags", int'({res_id, res_dz, res_ovf}), 0);
    chk("rst_div_xy", int'({div_x, div_y}), 0);
    do_reset;

    for (int i = 0; i < 12; i++) run_vec(vt[i], i);

    // Round robin with both requesters valid continuously.
    do_reset;
    req0_valid = 1'b1; req0_x = 4'd7; req0_y = 4'd3;
    req1_valid = 1'b1; req1_x = 4'b1010; req1_y = 4'd4;
    res_ready = 1'b1; both = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (accs.size() >= 8) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      #1;
      if (req0_ready && req1_ready) both = 1'b1;
      if (req0_valid && req0_ready) accs.push_back(0);
      if (req1_valid && req1_ready) accs.push_back(1);
      if (res_valid) rq.push_back('{int'($signed(res_z)), int'($signed(res_r)), int'(res_id)});
      @(negedge clock);
    end
    chk("rr_two_readies", int'(both), 0);
    chk("rr_acc_count", accs.size(), 8);
    for (int i = 0; i < accs.size() && i < 8; i++) chk($sformatf("rr_acc_%0d", i), accs[i], i % 2);
    chk_alt("rr_res", rq, 8);
    #1;
    chk("rr_busy_end", int'(busy), 0);

    // Credit limit under backpressure, head stability, then drain.
    do_reset;
    req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b0;
    nacc = 0; held = 1'b0; hz = 0; hr = 0; hid = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req0_ready || req1_ready) nacc++;
      if (res_valid && !held) begin
        held = 1'b1; hz = int'($signed(res_z)); hr = int'($signed(res_r)); hid = int'(res_id);
      end
      @(negedge clock);
    end
    #1;
    chk("cr_acc_count", nacc, DEPTH);
    chk("cr_ready0_low", int'(req0_ready), 0);
    chk("cr_ready1_low", int'(req1_ready), 0);
    chk("cr_head_valid", int'(res_valid), 1);
    chk("cr_head_stable_z", int'($signed(res_z)), hz);
    chk("cr_head_stable_r", int'($signed(res_r)), hr);
    chk("cr_head_stable_id", int'(res_id), hid);
    chk("cr_head_z", int'($signed(res_z)), 2);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clock);
    res_ready = 1'b1;
    rq.delete();
    for (int i = 0; i < 20; i++) begin
      #1;
      if (res_valid) rq.push_back('{int'($signed(res_z)), int'($signed(res_r)), int'(res_id)});
      @(negedge clock);
    end
    chk_alt("cr_drain", rq, DEPTH);
    #1;
    chk("cr_busy_end", int'(busy), 0);

    // Simultaneous pop and write while the FIFO holds DEPTH-1 entries.
    do_reset;
    req0_valid = 1'b1; req1_valid = 1'b1;
    nacc = 0; rq.delete();
    for (int i = 0; i < 40; i++) begin
      if (nacc >= 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      res_ready = (i == 8) || (i >= 13);
      #1;
      if (req0_ready || req1_ready) nacc++;
      if (res_valid && res_ready) rq.push_back('{int'($signed(res_z)), int'($signed(res_r)), int'(res_id)});
      @(negedge clock);
    end
    chk_alt("pw_res", rq, 4);

    // Reset two cycles after an accept discards the operation.
    do_reset;
    res_ready = 1'b1;
    req0_valid = 1'b1; req0_x = 4'd7; req0_y = 4'd3;
    #1;
    chk("mr_accept", int'(req0_ready), 1);
    @(posedge clock);
    @(negedge clock);
    req0_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1; req0_valid = 1'b1;
    #1;
    chk("mr_ready_in_reset", int'(req0_ready), 0);
    @(negedge clock);
    reset = 1'b0; req0_valid = 1'b0;
    #1;
    chk("mr_busy_after", int'(busy), 0);
    nres = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (res_valid) nres++;
      @(negedge clock);
    end
    chk("mr_no_result", nres, 0);
    run_vec(vt[0], 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/intdiv_sched.md
INTDIV_SCHED -- requirements
Module: intdiv_sched

Interface
REQ-001 Parameter N, default 4, operand/result width in bits (two's complement).
REQ-002 Parameter LAT, default 4, divider latency: clock edges from div_x/div_y change to valid div_z/div_r.
REQ-003 Parameter DEPTH, default 4, result FIFO entries; DEPTH SHALL be >= 1.
REQ-004 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-005 Ports (name  direction  width  meaning):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req0_valid/req1_valid  in  1  requester 0/1 holds an operation
- req0_x/req1_x  in  N  dividend
- req0_y/req1_y  in  N  divisor
- req0_ready/req1_ready  out  1  operation accepted this cycle when valid&ready
- div_x, div_y  out  N  registered operands to the pipelined divider
- div_z, div_r  in  N  quotient and remainder from the divider
- res_valid  out  1  FIFO head valid
- res_ready  in  1  consumer pops head when valid&ready
- res_z, res_r  out  N  quotient, remainder
- res_id  out  1  originating requester
- res_dz  out  1  divide by zero
- res_ovf  out  1  overflow (-2^(N-1) / -1)
- busy  out  1  any operation in flight or buffered

Function
REQ-006 Credit: accept only if inflight + fifo_count < DEPTH, using start-of-cycle values; a same-cycle pop frees credit next cycle.
REQ-007 Arbitration: round-robin. Both valid -> grant the pointer side. Pointer moves to the other requester after each accept. One valid -> grant it regardless of pointer.
REQ-008 reqN_ready combinational: high only for the granted requester, only with credit, never during reset. At most one ready per cycle.
REQ-009 On accept at edge t: div_x/div_y load operands; tag {valid, id, dz, ovf} enters an LAT-deep shift register; div_x/div_y hold when idle.
REQ-010 dz = (y==0); ovf = (x==-2^(N-1) && y==-1), both computed at accept.
REQ-011 At edge t+LAT the tag exits. The entry is written to the FIFO: div_z/div_r, or substitutes.
- dz: z = all ones, r = x (x carried in tag).
- ovf: z = -2^(N-1), r = 0.
REQ-012 res_valid rises at edge t+LAT+1 at earliest (FIFO empty, no backpressure). Results leave in accept order.
REQ-013 Simultaneous FIFO write and pop SHALL both take effect; count unchanged.
REQ-014 FIFO SHALL never overflow (guaranteed by REQ-006). res_* SHALL hold stable while res_valid & !res_ready.
REQ-015 FIFO pointers wrap modulo DEPTH. Throughput: one accept per cycle while credit exists.
REQ-016 busy = (inflight != 0) || (fifo_count != 0).

Reset
REQ-017 While reset is high at an edge, clear all state: tag register, FIFO count/pointers, pointer to requester 0, div_x = div_y = 0.
REQ-018 Outputs after reset: res_valid = 0, busy = 0, res_z/res_r/res_id/res_dz/res_ovf = 0, req*_ready = 0 while reset is high.
REQ-019 Reset mid-operation discards in-flight and buffered results. div_z/div_r values arriving after reset are ignored.

Verification
REQ-020 N=4, LAT=4: req0 x=7, y=3 accepted at edge t -> res_valid at t+5 with z=2, r=1, id=0, dz=0, ovf=0.
REQ-021 Both requesters valid continuously (req0 7/3, req1 -6/4), res_ready=1 -> accepts alternate 0,1,0,1. Results in order: (2,1,id0), (-1,-2,id1), repeating.
REQ-022 req0 x=5, y=0 -> z=4'hF, r=5, dz=1. req0 x=-8, y=-1 -> z=-8, r=0, ovf=1.
REQ-023 res_ready=0 with continuous requests -> exactly DEPTH accepts, then readies low. Releasing res_ready drains all DEPTH results in order, none lost or duplicated.
REQ-024 Assert reset two cycles after an accept -> res_valid never asserts for that operation. busy=0 the cycle after reset. A new request accepted normally afterwards.
REQ-025 Pop and write in the same cycle with FIFO full-1 -> count unchanged, no drop.
